// File: rtl/pipe_if_stage.sv
// Purpose: instruction-fetch stage with PC register, IF/ID pipeline register and BOOT/RUN/HOLD control FSM.
// Latency: one cycle, so the word fetched while pc_o=X appears on IF/ID at the next rising edge.
// Backpressure: stall_i freezes PC and IF/ID; branch_taken_i overrides a stall, and flush_i only empties IF/ID.
module pipe_if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 32
) (
    input  logic             clk_i,
    input  logic             rst_n,
    output logic [31:0]      im_addr_o,
    input  logic [31:0]      im_data_i,
    input  logic             stall_i,
    input  logic             branch_taken_i,
    input  logic [31:0]      branch_target_i,
    input  logic             flush_i,
    output logic [31:0]      pc_o,
    output logic [31:0]      ifid_instr_o,
    output logic [31:0]      ifid_pc4_o,
    output logic             ifid_valid_o,
    output logic [CNT_W-1:0] fetch_cnt_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t           r_state;
    state_t           w_state_nxt;
    logic [31:0]      r_pc;
    logic [31:0]      r_instr;
    logic [31:0]      r_pc4;
    logic             r_valid;
    logic [CNT_W-1:0] r_fetch_cnt;
    logic [CNT_W-1:0] r_stall_cnt;

    logic [31:0]      w_pc_plus4;
    logic [31:0]      w_target;
    logic [31:0]      w_pc_nxt;
    logic [31:0]      w_instr_nxt;
    logic [31:0]      w_pc4_nxt;
    logic             w_valid_nxt;
    logic             w_fetch_inc;
    logic             w_stall_inc;

    // PC+4 wraps naturally modulo 2^32; redirect targets are forced word-aligned.
    assign w_pc_plus4 = r_pc + 32'd4;
    assign w_target   = branch_target_i & 32'hFFFF_FFFC;

    // Next-state and next IF/ID contents; priority is redirect, then stall, then flush.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_instr_nxt = r_instr;
        w_pc4_nxt   = r_pc4;
        w_valid_nxt = r_valid;
        w_fetch_inc = 1'b0;
        w_stall_inc = 1'b0;
        case (r_state)
            ST_BOOT: begin
                // One idle cycle after reset release; nothing is fetched.
                w_state_nxt = ST_RUN;
            end
            ST_RUN, ST_HOLD: begin
                if (branch_taken_i) begin
                    w_state_nxt = ST_RUN;
                    w_pc_nxt    = w_target;
                    w_instr_nxt = 32'h0;
                    w_valid_nxt = 1'b0;
                end else if (stall_i) begin
                    w_state_nxt = ST_HOLD;
                    w_stall_inc = (r_state == ST_HOLD);
                    if (flush_i) begin
                        w_instr_nxt = 32'h0;
                        w_valid_nxt = 1'b0;
                    end
                end else begin
                    w_state_nxt = ST_RUN;
                    w_pc_nxt    = w_pc_plus4;
                    if (flush_i) begin
                        w_instr_nxt = 32'h0;
                        w_valid_nxt = 1'b0;
                    end else begin
                        w_instr_nxt = im_data_i;
                        w_pc4_nxt   = w_pc_plus4;
                        w_valid_nxt = 1'b1;
                        w_fetch_inc = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_BOOT;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_BOOT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // PC and IF/ID pipeline register.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_pc    <= RESET_PC;
            r_instr <= 32'h0;
            r_pc4   <= 32'h0;
            r_valid <= 1'b0;
        end else begin
            r_pc    <= w_pc_nxt;
            r_instr <= w_instr_nxt;
            r_pc4   <= w_pc4_nxt;
            r_valid <= w_valid_nxt;
        end
    end

    // Saturating performance counters: accepted fetches and HOLD-to-HOLD cycles.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_cnt <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (w_fetch_inc && (r_fetch_cnt != CNT_MAX)) begin
                r_fetch_cnt <= r_fetch_cnt + CNT_ONE;
            end
            if (w_stall_inc && (r_stall_cnt != CNT_MAX)) begin
                r_stall_cnt <= r_stall_cnt + CNT_ONE;
            end
        end
    end

    assign im_addr_o    = r_pc;
    assign pc_o         = r_pc;
    assign ifid_instr_o = r_instr;
    assign ifid_pc4_o   = r_pc4;
    assign ifid_valid_o = r_valid;
    assign fetch_cnt_o  = r_fetch_cnt;
    assign stall_cnt_o  = r_stall_cnt;

endmodule

// File: doc/pipe_if_stage.md
PIPE_IF_STAGE -- requirements
Module: pipe_if_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, the PC value loaded on reset.
REQ-002 Parameter CNT_W, default 32, the width of the performance counters.
REQ-003 clk_i  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 im_addr_o  output  32  instruction-memory byte address; always equals pc_o.
REQ-006 im_data_i  input  32  instruction word, combinationally returned for im_addr_o.
REQ-007 stall_i  input  1  hazard stall from decode; holds PC and IF/ID.
REQ-008 branch_taken_i  input  1  redirect request from the branch-resolving stage.
REQ-009 branch_target_i  input  32  redirect byte address.
REQ-010 flush_i  input  1  invalidates IF/ID without redirecting.
REQ-011 pc_o  output  32  current fetch PC.
REQ-012 ifid_instr_o  output  32  registered instruction passed to decode.
REQ-013 ifid_pc4_o  output  32  registered PC+4 of that instruction.
REQ-014 ifid_valid_o  output  1  IF/ID holds a real instruction.
REQ-015 fetch_cnt_o  output  CNT_W  count of instructions accepted into IF/ID.
REQ-016 stall_cnt_o  output  CNT_W  count of cycles spent in HOLD.

Function
REQ-017 The FSM SHALL have three states: BOOT, RUN and HOLD.
REQ-018 BOOT SHALL last exactly one cycle after rst_n deasserts, with no fetch and ifid_valid_o=0, then go to RUN.
REQ-019 In RUN with no control input asserted, each edge SHALL set PC to PC+4, ifid_instr_o to im_data_i, ifid_pc4_o to PC+4 and ifid_valid_o to 1.
REQ-020 In RUN, stall_i=1 with branch_taken_i=0 SHALL hold PC and all IF/ID outputs unchanged and move the FSM to HOLD.
REQ-021 HOLD SHALL stay in HOLD while stall_i=1 and return to RUN on the first cycle stall_i=0, fetching normally in that cycle.
REQ-022 branch_taken_i=1 in RUN or HOLD SHALL load PC with {branch_target_i[31:2],2'b00}, set ifid_instr_o to 0, set ifid_valid_o to 0, and move the FSM to RUN.
REQ-023 Priority SHALL be branch_taken_i > stall_i > flush_i.
REQ-024 flush_i=1 alone SHALL clear ifid_valid_o and ifid_instr_o while PC advances by 4.
REQ-025 flush_i together with stall_i, without branch_taken_i, SHALL clear IF/ID and hold PC.
REQ-026 The PC SHALL wrap modulo 2^32: PC 32'hFFFF_FFFC advances to 32'h0000_0000.
REQ-027 fetch_cnt_o SHALL increment on each edge that writes ifid_valid_o=1.
REQ-028 stall_cnt_o SHALL increment on each edge where the FSM is in HOLD and stays in HOLD.
REQ-029 Both counters SHALL saturate at all-ones.
REQ-030 Latency SHALL be one cycle: an instruction at PC X appears on IF/ID on the edge after pc_o=X.

Reset
REQ-031 While rst_n=0 the block SHALL force pc_o=RESET_PC, ifid_instr_o=0, ifid_pc4_o=0, ifid_valid_o=0, both counters=0 and FSM=BOOT, independent of clk_i.
REQ-032 Assertion of rst_n mid-stall or mid-redirect SHALL discard the pending operation; the first fetch after release is at RESET_PC.

Verification
REQ-033 Reset release, then 4 clean cycles, with IM[n]=n+1 -> ifid_instr_o sequence 1,2,3, ifid_pc4_o 4,8,12, fetch_cnt_o=3, pc_o=12.
REQ-034 stall_i high for 3 cycles at pc_o=8 -> pc_o stays 8, IF/ID frozen, stall_cnt_o=2, then resume fetching at 8.
REQ-035 branch_taken_i and stall_i together, target 32'h0000_0043 -> pc_o=32'h40 next cycle, ifid_valid_o=0, FSM=RUN.
REQ-036 flush_i alone at pc_o=16 -> ifid_valid_o=0, ifid_instr_o=0, pc_o=20, fetch_cnt_o unchanged.
REQ-037 Redirect to 32'hFFFF_FFFC, then 2 free cycles -> pc_o goes 0xFFFFFFFC, 0x0, 0x4, with ifid_pc4_o=0 for the wrapped word.
REQ-038 rst_n pulsed low asynchronously mid-HOLD at pc_o=24 -> outputs go to reset values immediately; after release, 1 BOOT cycle, then fetch at RESET_PC.
